// File: rtl/multicycle_pkg.sv
// Shared types and constants for the multicycle control FSM: state codes,
// opcode values, ALU operation selects and the decoded instruction class.
package multicycle_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_NOP  = 7'b0000000;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  typedef enum logic [2:0] {
    CLS_NOP  = 3'd0,
    CLS_R    = 3'd1,
    CLS_IALU = 3'd2,
    CLS_LW   = 3'd3,
    CLS_SW   = 3'd4,
    CLS_BEQ  = 3'd5
  } opclass_e;

endpackage

// File: rtl/opclass_decode.sv
// Maps a 7-bit opcode to its instruction class; anything unrecognised is
// flagged illegal and reported as NOP class.
module opclass_decode
  import multicycle_pkg::*;
(
  input  logic [6:0] opcode,
  output opclass_e   cls,
  output logic       illegal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    cls     = CLS_NOP;
    illegal = 1'b0;
    case (opcode)
      OP_R:    cls = CLS_R;
      OP_IALU: cls = CLS_IALU;
      OP_LW:   cls = CLS_LW;
      OP_SW:   cls = CLS_SW;
      OP_BEQ:  cls = CLS_BEQ;
      OP_NOP:  cls = CLS_NOP;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM (IF/ID/EX/MEM/WB/HALT) with a shared-memory
// handshake, a wait-cycle watchdog and a retired-instruction counter.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int WAIT_W   = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        irwrite,
  output logic        pcwrite,
  output logic        pcsrc,
  output logic        regwrite,
  output logic        memtoreg,
  output logic        alusrc,
  output logic [1:0]  aluop,
  output logic [2:0]  state,
  output logic        halted,
  output logic        err,
  output logic        retire,
  output logic [31:0] instret
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

  state_e            state_q, state_d;
  opclass_e          cls_q, cls_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;
  logic [31:0]       instret_q, instret_d;

  opclass_e dec_cls;
  logic     dec_illegal;

  logic       mem_req_c, mem_we_c, iord_c, irwrite_c, pcwrite_c, pcsrc_c;
  logic       regwrite_c, memtoreg_c, alusrc_c, retire_c;
  logic [1:0] aluop_c;

  opclass_decode u_decode (
    .opcode  (opcode),
    .cls     (dec_cls),
    .illegal (dec_illegal)
  );

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    wait_d     = wait_q;
    err_d      = err_q;
    mem_req_c  = 1'b0;
    mem_we_c   = 1'b0;
    iord_c     = 1'b0;
    irwrite_c  = 1'b0;
    pcwrite_c  = 1'b0;
    pcsrc_c    = 1'b0;
    regwrite_c = 1'b0;
    memtoreg_c = 1'b0;
    alusrc_c   = 1'b0;
    aluop_c    = ALUOP_ADD;
    retire_c   = 1'b0;

    case (state_q)
      S_IF: begin
        mem_req_c = 1'b1;
        if (mem_ready) begin
          irwrite_c = 1'b1;
          pcwrite_c = 1'b1;
          state_d   = S_ID;
        end else if (wait_q == MAX_WAIT_C) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_ONE;
        end
      end
      S_ID: begin
        cls_d = dec_cls;
        if (dec_illegal) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else if (dec_cls == CLS_NOP) begin
          state_d  = S_IF;
          retire_c = 1'b1;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        case (cls_q)
          CLS_R: begin
            aluop_c = ALUOP_FUNCT;
            state_d = S_WB;
          end
          CLS_IALU: begin
            alusrc_c = 1'b1;
            state_d  = S_WB;
          end
          CLS_LW, CLS_SW: begin
            alusrc_c = 1'b1;
            state_d  = S_MEM;
          end
          CLS_BEQ: begin
            aluop_c   = ALUOP_SUB;
            pcsrc_c   = 1'b1;
            pcwrite_c = zero;
            retire_c  = 1'b1;
            state_d   = S_IF;
          end
          default: state_d = S_IF;
        endcase
      end
      S_MEM: begin
        mem_req_c = 1'b1;
        iord_c    = 1'b1;
        mem_we_c  = (cls_q == CLS_SW);
        if (mem_ready) begin
          if (cls_q == CLS_LW) begin
            state_d = S_WB;
          end else begin
            retire_c = 1'b1;
            state_d  = S_IF;
          end
        end else if (wait_q == MAX_WAIT_C) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_ONE;
        end
      end
      S_WB: begin
        regwrite_c = 1'b1;
        memtoreg_c = (cls_q == CLS_LW);
        retire_c   = 1'b1;
        state_d    = S_IF;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase

    // The watchdog restarts from zero whenever a new state (IF or MEM) begins.
    if (state_d != state_q) wait_d = '0;

    instret_d = retire_c ? instret_q + 32'd1 : instret_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    if (!rst) begin
      state_q   <= S_IF;
      cls_q     <= CLS_NOP;
      wait_q    <= '0;
      err_q     <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      wait_q    <= wait_d;
      err_q     <= err_d;
      instret_q <= instret_d;
    end
  end

  // Gating with rst makes a reset abort an in-flight access in the same cycle.
  assign mem_req  = rst & mem_req_c;
  assign mem_we   = rst & mem_we_c;
  assign iord     = rst & iord_c;
  assign irwrite  = rst & irwrite_c;
  assign pcwrite  = rst & pcwrite_c;
  assign pcsrc    = rst & pcsrc_c;
  assign regwrite = rst & regwrite_c;
  assign memtoreg = rst & memtoreg_c;
  assign alusrc   = rst & alusrc_c;
  assign retire   = rst & retire_c;
  assign aluop    = rst ? aluop_c : 2'd0;
  assign state    = state_q;
  assign halted   = (state_q == S_HALT);
  assign err      = err_q;
  assign instret  = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each stimulus cycle queues the
// hand-computed output vector; a negedge monitor pops and compares.
module tb_multicycle_ctrl;
  import multicycle_pkg::*;

  logic        clk, rst;
  logic [6:0]  opcode;
  logic        zero, mem_ready;
  logic        mem_req, mem_we, iord, irwrite, pcwrite, pcsrc;
  logic        regwrite, memtoreg, alusrc, halted, err, retire;
  logic [1:0]  aluop;
  logic [2:0]  state;
  logic [31:0] instret;

  // Strobe order: mem_req mem_we iord irwrite pcwrite pcsrc regwrite memtoreg alusrc
  localparam logic [8:0] SB_NONE  = 9'b000000000;
  localparam logic [8:0] SB_FETCH = 9'b100110000;
  localparam logic [8:0] SB_REQ   = 9'b100000000;
  localparam logic [8:0] SB_ALUI  = 9'b000000001;
  localparam logic [8:0] SB_DRD   = 9'b101000000;
  localparam logic [8:0] SB_DWR   = 9'b111000000;
  localparam logic [8:0] SB_WB    = 9'b000000100;
  localparam logic [8:0] SB_WBLD  = 9'b000000110;
  localparam logic [8:0] SB_BRT   = 9'b000011000;
  localparam logic [8:0] SB_BNT   = 9'b000001000;
  // Flag order: halted err retire
  localparam logic [2:0] F_0    = 3'b000;
  localparam logic [2:0] F_RET  = 3'b001;
  localparam logic [2:0] F_HALT = 3'b110;

  typedef struct {
    string       name;
    logic [48:0] vec;
  } exp_t;

  exp_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  logic [48:0] act;
  assign act = {state, mem_req, mem_we, iord, irwrite, pcwrite, pcsrc, regwrite,
                memtoreg, alusrc, aluop, halted, err, retire, instret};

  multicycle_ctrl #(.WAIT_W(4), .MAX_WAIT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .iord      (iord),
    .irwrite   (irwrite),
    .pcwrite   (pcwrite),
    .pcsrc     (pcsrc),
    .regwrite  (regwrite),
    .memtoreg  (memtoreg),
    .alusrc    (alusrc),
    .aluop     (aluop),
    .state     (state),
    .halted    (halted),
    .err       (err),
    .retire    (retire),
    .instret   (instret)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc(input logic r, input logic [6:0] op, input logic z,
                     input logic rdy, input string nm, input state_e st,
                     input logic [8:0] strb, input logic [1:0] aop,
                     input logic [2:0] flg, input logic [31:0] ir);
    exp_t e;
    @(posedge clk);
    #1;
    rst       = r;
    opcode    = op;
    zero      = z;
    mem_ready = rdy;
    e.name    = nm;
    e.vec     = {st, strb, aop, flg, ir};
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        tests_run++;
        if (act !== e.vec) begin
          tests_failed++;
          $display("FAIL %s: got st=%0d strb=%b aluop=%0d flg=%b instret=%0d, want st=%0d strb=%b aluop=%0d flg=%b instret=%0d",
                   e.name, act[48:46], act[45:37], act[36:35], act[34:32], act[31:0],
                   e.vec[48:46], e.vec[45:37], e.vec[36:35], e.vec[34:32], e.vec[31:0]);
        end
      end
    end
  end

  initial begin : stim
    rst = 1'b0; opcode = OP_NOP; zero = 1'b0; mem_ready = 1'b0;

    cyc(0, OP_R, 0, 1, "reset0", S_IF, SB_NONE, 0, F_0, 0);
    cyc(0, OP_R, 0, 1, "reset1", S_IF, SB_NONE, 0, F_0, 0);

    // R-type, zero-wait memory
    cyc(1, OP_R, 0, 1, "r_if", S_IF,  SB_FETCH, 0, F_0,   0);
    cyc(1, OP_R, 0, 1, "r_id", S_ID,  SB_NONE,  0, F_0,   0);
    cyc(1, OP_R, 0, 1, "r_ex", S_EX,  SB_NONE,  2, F_0,   0);
    cyc(1, OP_R, 0, 1, "r_wb", S_WB,  SB_WB,    0, F_RET, 0);

    // LW with three wait cycles in MEM
    cyc(1, OP_LW, 0, 1, "lw_if", S_IF, SB_FETCH, 0, F_0, 1);
    cyc(1, OP_LW, 0, 1, "lw_id", S_ID, SB_NONE,  0, F_0, 1);
    cyc(1, OP_LW, 0, 1, "lw_ex", S_EX, SB_ALUI,  0, F_0, 1);
    for (int i = 0; i < 3; i++)
      cyc(1, OP_LW, 0, 0, "lw_mem_wait", S_MEM, SB_DRD, 0, F_0, 1);
    cyc(1, OP_LW, 0, 1, "lw_mem_done", S_MEM, SB_DRD,  0, F_0,   1);
    cyc(1, OP_LW, 0, 1, "lw_wb",       S_WB,  SB_WBLD, 0, F_RET, 1);

    // BEQ taken then not taken
    cyc(1, OP_BEQ, 1, 1, "beq_t_if", S_IF, SB_FETCH, 0, F_0,   2);
    cyc(1, OP_BEQ, 1, 1, "beq_t_id", S_ID, SB_NONE,  0, F_0,   2);
    cyc(1, OP_BEQ, 1, 1, "beq_t_ex", S_EX, SB_BRT,   1, F_RET, 2);
    cyc(1, OP_BEQ, 0, 1, "beq_n_if", S_IF, SB_FETCH, 0, F_0,   3);
    cyc(1, OP_BEQ, 0, 1, "beq_n_id", S_ID, SB_NONE,  0, F_0,   3);
    cyc(1, OP_BEQ, 0, 1, "beq_n_ex", S_EX, SB_BNT,   1, F_RET, 3);

    // NOP retires straight from ID
    cyc(1, OP_NOP, 0, 1, "nop_if", S_IF, SB_FETCH, 0, F_0,   4);
    cyc(1, OP_NOP, 0, 1, "nop_id", S_ID, SB_NONE,  0, F_RET, 4);

    // SW aborted by reset mid-access
    cyc(1, OP_SW, 0, 1, "sw_if",  S_IF,  SB_FETCH, 0, F_0, 5);
    cyc(1, OP_SW, 0, 1, "sw_id",  S_ID,  SB_NONE,  0, F_0, 5);
    cyc(1, OP_SW, 0, 1, "sw_ex",  S_EX,  SB_ALUI,  0, F_0, 5);
    cyc(1, OP_SW, 0, 0, "sw_mem", S_MEM, SB_DWR,   0, F_0, 5);
    cyc(0, OP_SW, 0, 0, "sw_rst", S_IF,  SB_NONE,  0, F_0, 0);

    // Illegal opcode halts from ID; HALT is sticky
    cyc(1, 7'b1111111, 0, 1, "ill_if", S_IF, SB_FETCH, 0, F_0, 0);
    cyc(1, 7'b1111111, 0, 1, "ill_id", S_ID, SB_NONE,  0, F_0, 0);
    for (int i = 0; i < 3; i++)
      cyc(1, 7'b1111111, 0, 1, "ill_halt", S_HALT, SB_NONE, 0, F_HALT, 0);
    cyc(0, OP_NOP, 0, 0, "rst_after_halt", S_IF, SB_NONE, 0, F_0, 0);

    // mem_ready on the last allowed wait cycle beats the fault
    for (int i = 0; i < 15; i++)
      cyc(1, OP_NOP, 0, 0, "if_wait", S_IF, SB_REQ, 0, F_0, 0);
    cyc(1, OP_NOP, 0, 1, "if_ready_wins", S_IF, SB_FETCH, 0, F_0,   0);
    cyc(1, OP_NOP, 0, 0, "nop_id2",       S_ID, SB_NONE,  0, F_RET, 0);

    // mem_ready never arrives: 16 request cycles, then HALT with err
    for (int i = 0; i < 16; i++)
      cyc(1, OP_NOP, 0, 0, "if_timeout_wait", S_IF, SB_REQ, 0, F_0, 1);
    for (int i = 0; i < 3; i++)
      cyc(1, OP_NOP, 0, 1, "timeout_halt", S_HALT, SB_NONE, 0, F_HALT, 1);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
